// File: rtl/rob_pkg.sv
// -----------------------------------------------------------------------------
// rob_pkg
// Shared types for the reorder buffer slice:
//   - rob_kind_e  : 3-bit instruction class recorded per entry
//   - rob_state_e : 2-bit per-entry lifecycle state
//   - RV32 major opcodes and the opcode-to-kind mapping used by decode
//   - small helpers that classify a kind
// No ports (package).
// -----------------------------------------------------------------------------
package rob_pkg;

    typedef enum logic [2:0] {
        KIND_ALU    = 3'd0,
        KIND_LOAD   = 3'd1,
        KIND_STORE  = 3'd2,
        KIND_BRANCH = 3'd3,
        KIND_JALR   = 3'd4,
        KIND_DONE   = 3'd5   // LUI / AUIPC / JAL: result known at decode
    } rob_kind_e;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SREADY = 2'd2,    // store has its result, waiting for the LSB
        ST_DONE   = 2'd3
    } rob_state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    function automatic rob_kind_e opcode_to_kind(input logic [6:0] opcode);
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: return KIND_DONE;
            OPC_JALR:                    return KIND_JALR;
            OPC_BRANCH:                  return KIND_BRANCH;
            OPC_LOAD:                    return KIND_LOAD;
            OPC_STORE:                   return KIND_STORE;
            default:                     return KIND_ALU;
        endcase
    endfunction

    // Stores and branches never write the register file.
    function automatic logic kind_writes_rd(input rob_kind_e kind);
        return !(kind == KIND_STORE || kind == KIND_BRANCH);
    endfunction

    function automatic logic kind_is_done(input rob_kind_e kind);
        return (kind == KIND_DONE);
    endfunction

endpackage

// File: rtl/reorder_buffer_v2_if.sv
// -----------------------------------------------------------------------------
// reorder_buffer_v2_if
// Bundles every handshake/bus signal of the reorder buffer:
//   alloc_*        decode-side allocation
//   cdb_*          NUM_CDB result buses
//   query_*        two operand lookups
//   commit_*       register-file retirement
//   store_commit_* LSB store gating
//   flush_out / redirect_pc_out, full_out / count_out
// Modports: slave = the reorder buffer, master = the surrounding core.
// -----------------------------------------------------------------------------
interface reorder_buffer_v2_if #(
    parameter int DEPTH   = 16,
    parameter int XLEN    = 32,
    parameter int NUM_CDB = 2,
    parameter int RF_AW   = 5
);
    localparam int ID_W = $clog2(DEPTH);

    logic                      alloc_valid_in;
    logic                      alloc_ready_out;
    logic [ID_W-1:0]           alloc_id_out;
    logic [2:0]                alloc_kind_in;
    logic [RF_AW-1:0]          alloc_rd_in;
    logic [XLEN-1:0]           alloc_value_in;
    logic                      alloc_pred_taken_in;

    logic [NUM_CDB-1:0]        cdb_valid_in;
    logic [NUM_CDB*ID_W-1:0]   cdb_id_in;
    logic [NUM_CDB*XLEN-1:0]   cdb_value_in;
    logic [NUM_CDB-1:0]        cdb_taken_in;
    logic [NUM_CDB*XLEN-1:0]   cdb_npc_in;

    logic [2*ID_W-1:0]         query_id_in;
    logic [1:0]                query_ready_out;
    logic [2*XLEN-1:0]         query_value_out;

    logic                      commit_valid_out;
    logic [ID_W-1:0]           commit_id_out;
    logic [RF_AW-1:0]          commit_rd_out;
    logic [XLEN-1:0]           commit_value_out;

    logic                      store_commit_valid_out;
    logic                      store_commit_ack_in;

    logic                      flush_out;
    logic [XLEN-1:0]           redirect_pc_out;
    logic                      full_out;
    logic [ID_W:0]             count_out;

    modport slave (
        input  alloc_valid_in, alloc_kind_in, alloc_rd_in, alloc_value_in,
               alloc_pred_taken_in,
        output alloc_ready_out, alloc_id_out,
        input  cdb_valid_in, cdb_id_in, cdb_value_in, cdb_taken_in, cdb_npc_in,
        input  query_id_in,
        output query_ready_out, query_value_out,
        output commit_valid_out, commit_id_out, commit_rd_out, commit_value_out,
        output store_commit_valid_out,
        input  store_commit_ack_in,
        output flush_out, redirect_pc_out, full_out, count_out
    );

    modport master (
        output alloc_valid_in, alloc_kind_in, alloc_rd_in, alloc_value_in,
               alloc_pred_taken_in,
        input  alloc_ready_out, alloc_id_out,
        output cdb_valid_in, cdb_id_in, cdb_value_in, cdb_taken_in, cdb_npc_in,
        output query_id_in,
        input  query_ready_out, query_value_out,
        input  commit_valid_out, commit_id_out, commit_rd_out, commit_value_out,
        input  store_commit_valid_out,
        output store_commit_ack_in,
        input  flush_out, redirect_pc_out, full_out, count_out
    );

endinterface

// File: rtl/rob_query_port.sv
// -----------------------------------------------------------------------------
// rob_query_port
// One operand-lookup port of the reorder buffer. Purely combinational.
//   query_id_in      entry to look up
//   st_in / val_in   entry state and result arrays of the buffer
//   cdb_hit_in / cdb_id_in / cdb_value_in   (ROB_BYPASS_EN only) CDB writes
//                    that land on a WAIT entry this cycle
//   ready_out        entry result available
//   value_out        entry result (zero when not ready)
// Build option: ROB_BYPASS_EN forwards same-cycle CDB results; without it a
// result becomes visible the cycle after its CDB write.
// -----------------------------------------------------------------------------
module rob_query_port
    import rob_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int XLEN    = 32,
    parameter int NUM_CDB = 2,
    parameter int ID_W    = $clog2(DEPTH)
) (
    input  logic [ID_W-1:0] query_id_in,
    input  rob_state_e      st_in      [DEPTH],
    input  logic [XLEN-1:0] val_in     [DEPTH],
`ifdef ROB_BYPASS_EN
    input  logic            cdb_hit_in   [NUM_CDB],
    input  logic [ID_W-1:0] cdb_id_in    [NUM_CDB],
    input  logic [XLEN-1:0] cdb_value_in [NUM_CDB],
`endif
    output logic            ready_out,
    output logic [XLEN-1:0] value_out
);

    always_comb begin
        ready_out = (st_in[query_id_in] == ST_DONE) ||
                    (st_in[query_id_in] == ST_SREADY);
        value_out = ready_out ? val_in[query_id_in] : '0;
`ifdef ROB_BYPASS_EN
        // Ascending scan so the highest channel wins, matching the write order.
        for (int k = 0; k < NUM_CDB; k++) begin
            if (cdb_hit_in[k] && (cdb_id_in[k] == query_id_in)) begin
                ready_out = 1'b1;
                value_out = cdb_value_in[k];
            end
        end
`endif
    end

endmodule

// File: rtl/reorder_buffer_v2.sv
// -----------------------------------------------------------------------------
// reorder_buffer_v2
// In-order-commit reorder buffer. Allocates entries at the tail from decode,
// completes them from NUM_CDB result buses, serves two operand lookups,
// retires one head entry per cycle, gates store retirement through the LSB,
// and flushes everything when a committing branch mispredicted or a JALR
// retires.
// Ports:
//   clk_in    clock
//   rst_n_in  asynchronous active-low reset
//   rdy_in    global enable; low freezes all state
//   rob       reorder_buffer_v2_if.slave (alloc, cdb, query, commit, store,
//             flush/redirect, full/count)
// Build option: ROB_BYPASS_EN enables same-cycle CDB forwarding on queries.
// -----------------------------------------------------------------------------
module reorder_buffer_v2
    import rob_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int XLEN    = 32,
    parameter int NUM_CDB = 2,
    parameter int RF_AW   = 5
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               rdy_in,
    reorder_buffer_v2_if.slave rob
);

    localparam int ID_W = $clog2(DEPTH);
    localparam logic [ID_W-1:0] ID_ONE   = ID_W'(1);
    localparam logic [ID_W:0]   CNT_ONE  = (ID_W+1)'(1);
    localparam logic [ID_W:0]   CNT_FULL = (ID_W+1)'(DEPTH);

    // Control state (reset)
    rob_state_e      st [DEPTH];
    logic [ID_W-1:0] head;
    logic [ID_W-1:0] tail;
    logic [ID_W:0]   count;

    // Entry payload (not reset; qualified by st)
    rob_kind_e        kind_q  [DEPTH];
    logic [RF_AW-1:0] rd_q    [DEPTH];
    logic [XLEN-1:0]  val_q   [DEPTH];
    logic [XLEN-1:0]  npc_q   [DEPTH];
    logic             taken_q [DEPTH];
    logic             pred_q  [DEPTH];

    // Unpacked CDB channels
    logic [ID_W-1:0] cdb_id  [NUM_CDB];
    logic [XLEN-1:0] cdb_val [NUM_CDB];
    logic [XLEN-1:0] cdb_npc [NUM_CDB];
    logic            cdb_hit [NUM_CDB];

    logic       empty;
    logic       full;
    logic       head_done;
    logic       head_sready;
    logic       commit_fire;
    logic       redirect;
    logic       flush;
    logic       alloc_ready;
    logic       alloc_fire;
    logic       store_fire;
    rob_kind_e  alloc_kind;
    rob_kind_e  head_kind;

    assign alloc_kind = rob_kind_e'(rob.alloc_kind_in);
    assign head_kind  = kind_q[head];

    always_comb begin
        for (int k = 0; k < NUM_CDB; k++) begin
            cdb_id[k]  = rob.cdb_id_in[k*ID_W +: ID_W];
            cdb_val[k] = rob.cdb_value_in[k*XLEN +: XLEN];
            cdb_npc[k] = rob.cdb_npc_in[k*XLEN +: XLEN];
            // Only WAIT entries accept results; EMPTY/DONE/SREADY ignore them.
            cdb_hit[k] = rob.cdb_valid_in[k] && (st[cdb_id[k]] == ST_WAIT);
        end
    end

    always_comb begin
        empty       = (count == '0);
        full        = (count == CNT_FULL);
        head_done   = (st[head] == ST_DONE) && !empty;
        head_sready = (st[head] == ST_SREADY) && !empty;
        commit_fire = head_done && rdy_in;
        redirect    = (head_kind == KIND_JALR) ||
                      ((head_kind == KIND_BRANCH) && (taken_q[head] != pred_q[head]));
        flush       = commit_fire && redirect;
        alloc_ready = !full && !flush;
        alloc_fire  = rob.alloc_valid_in && alloc_ready && rdy_in;
        store_fire  = head_sready && rob.store_commit_ack_in && rdy_in;
    end

    // Stage boundary: control state update
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) st[i] <= ST_EMPTY;
        end else if (rdy_in) begin
            if (flush) begin
                // Same-cycle allocation and CDB writes are dropped with the rest.
                head  <= '0;
                tail  <= '0;
                count <= '0;
                for (int i = 0; i < DEPTH; i++) st[i] <= ST_EMPTY;
            end else begin
                if (alloc_fire) begin
                    st[tail] <= kind_is_done(alloc_kind) ? ST_DONE : ST_WAIT;
                    tail     <= tail + ID_ONE;
                end
                for (int k = 0; k < NUM_CDB; k++) begin
                    if (cdb_hit[k]) begin
                        st[cdb_id[k]] <= (kind_q[cdb_id[k]] == KIND_STORE) ?
                                         ST_SREADY : ST_DONE;
                    end
                end
                if (store_fire) st[head] <= ST_DONE;
                if (commit_fire) begin
                    st[head] <= ST_EMPTY;
                    head     <= head + ID_ONE;
                end
                case ({alloc_fire, commit_fire})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    // Stage boundary: entry payload capture
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (alloc_fire) begin
                kind_q[tail]  <= alloc_kind;
                rd_q[tail]    <= rob.alloc_rd_in;
                val_q[tail]   <= rob.alloc_value_in;
                pred_q[tail]  <= rob.alloc_pred_taken_in;
                taken_q[tail] <= 1'b0;
                npc_q[tail]   <= '0;
            end
            for (int k = 0; k < NUM_CDB; k++) begin
                if (cdb_hit[k]) begin
                    val_q[cdb_id[k]]   <= cdb_val[k];
                    npc_q[cdb_id[k]]   <= cdb_npc[k];
                    taken_q[cdb_id[k]] <= rob.cdb_taken_in[k];
                end
            end
        end
    end

    logic            q_ready [2];
    logic [XLEN-1:0] q_value [2];

    for (genvar i = 0; i < 2; i++) begin : g_query
        rob_query_port #(
            .DEPTH   (DEPTH),
            .XLEN    (XLEN),
            .NUM_CDB (NUM_CDB),
            .ID_W    (ID_W)
        ) u_query (
            .query_id_in  (rob.query_id_in[i*ID_W +: ID_W]),
            .st_in        (st),
            .val_in       (val_q),
`ifdef ROB_BYPASS_EN
            .cdb_hit_in   (cdb_hit),
            .cdb_id_in    (cdb_id),
            .cdb_value_in (cdb_val),
`endif
            .ready_out    (q_ready[i]),
            .value_out    (q_value[i])
        );
    end

    always_comb begin
        rob.alloc_ready_out        = alloc_ready;
        rob.alloc_id_out           = tail;
        rob.query_ready_out        = {q_ready[1], q_ready[0]};
        rob.query_value_out        = {q_value[1], q_value[0]};
        rob.commit_valid_out       = commit_fire;
        rob.commit_id_out          = head;
        rob.commit_rd_out          = (head_done && kind_writes_rd(head_kind)) ?
                                     rd_q[head] : '0;
        rob.commit_value_out       = head_done ? val_q[head] : '0;
        rob.store_commit_valid_out = head_sready;
        rob.flush_out              = flush;
        rob.redirect_pc_out        = flush ? npc_q[head] : '0;
        rob.full_out               = full;
        rob.count_out              = count;
    end

`ifndef SYNTHESIS
    // Two channels naming the same entry in one cycle is a protocol error.
    logic dup_cdb;
    always_comb begin
        dup_cdb = 1'b0;
        for (int j = 0; j < NUM_CDB; j++) begin
            for (int k = j + 1; k < NUM_CDB; k++) begin
                if (rob.cdb_valid_in[j] && rob.cdb_valid_in[k] && (cdb_id[j] == cdb_id[k]))
                    dup_cdb = 1'b1;
            end
        end
    end
    a_cdb_unique_id: assert property (@(posedge clk_in) disable iff (!rst_n_in) !dup_cdb);
`endif

endmodule

// File: tb/tb_reorder_buffer_v2.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer_v2
// Directed bench for reorder_buffer_v2 (DEPTH=16, XLEN=32, NUM_CDB=2).
// Inputs are driven 1 ns after the rising edge; outputs are checked 1 ns later.
// -----------------------------------------------------------------------------
module tb_reorder_buffer_v2;
    import rob_pkg::*;

    localparam int DEPTH = 16;
    localparam int XLEN  = 32;
    localparam int NCDB  = 2;
    localparam int RF_AW = 5;
    localparam int ID_W  = 4;

    logic clk_in;
    logic rst_n_in;
    logic rdy_in;

    int checks;
    int errors;

    reorder_buffer_v2_if #(.DEPTH(DEPTH), .XLEN(XLEN), .NUM_CDB(NCDB), .RF_AW(RF_AW)) rob_if ();

    reorder_buffer_v2 #(.DEPTH(DEPTH), .XLEN(XLEN), .NUM_CDB(NCDB), .RF_AW(RF_AW)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rdy_in   (rdy_in),
        .rob      (rob_if.slave)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rob_if.alloc_valid_in      = 1'b0;
        rob_if.alloc_kind_in       = KIND_ALU;
        rob_if.alloc_rd_in         = '0;
        rob_if.alloc_value_in      = '0;
        rob_if.alloc_pred_taken_in = 1'b0;
        rob_if.cdb_valid_in        = '0;
        rob_if.cdb_id_in           = '0;
        rob_if.cdb_value_in        = '0;
        rob_if.cdb_taken_in        = '0;
        rob_if.cdb_npc_in          = '0;
        rob_if.store_commit_ack_in = 1'b0;
    endtask

    task automatic alloc(input rob_kind_e kind, input logic [4:0] rd,
                         input logic [31:0] value, input logic pred);
        rob_if.alloc_valid_in      = 1'b1;
        rob_if.alloc_kind_in       = kind;
        rob_if.alloc_rd_in         = rd;
        rob_if.alloc_value_in      = value;
        rob_if.alloc_pred_taken_in = pred;
    endtask

    task automatic cdb(input int ch, input logic [3:0] id, input logic [31:0] value,
                       input logic taken, input logic [31:0] npc);
        rob_if.cdb_valid_in[ch]              = 1'b1;
        rob_if.cdb_id_in[ch*ID_W +: ID_W]    = id;
        rob_if.cdb_value_in[ch*XLEN +: XLEN] = value;
        rob_if.cdb_taken_in[ch]              = taken;
        rob_if.cdb_npc_in[ch*XLEN +: XLEN]   = npc;
    endtask

    task automatic do_reset();
        idle();
        rst_n_in = 1'b0;
        #1;
        rst_n_in = 1'b1;
    endtask

    logic [1:0]  exp_rdy;
    logic [31:0] exp_v0;
    logic [31:0] exp_v1;

    initial begin
        checks = 0;
        errors = 0;
        rst_n_in = 1'b0;
        rdy_in   = 1'b1;
        idle();
        rob_if.query_id_in = '0;

        // ---- reset state
        #12;
        chk("rst_count",       rob_if.count_out, 0);
        chk("rst_alloc_ready", rob_if.alloc_ready_out, 1);
        chk("rst_alloc_id",    rob_if.alloc_id_out, 0);
        chk("rst_commit_vld",  rob_if.commit_valid_out, 0);
        chk("rst_store_vld",   rob_if.store_commit_valid_out, 0);
        chk("rst_flush",       rob_if.flush_out, 0);
        chk("rst_full",        rob_if.full_out, 0);
        chk("rst_query_rdy",   rob_if.query_ready_out, 0);
        rst_n_in = 1'b1;

        // ---- fill to full, complete head, commit, refill slot 0
        for (int i = 0; i < 16; i++) begin
            alloc(KIND_ALU, 5'(i + 1), 32'h0, 1'b0);
            #1;
            chk("fill_alloc_id", rob_if.alloc_id_out, i);
            tick();
        end
        idle();
        alloc(KIND_ALU, 5'd30, 32'h0, 1'b0);   // must be blocked
        cdb(0, 4'd0, 32'hA0, 1'b0, 32'h0);
        #1;
        chk("full_flag",        rob_if.full_out, 1);
        chk("full_alloc_ready", rob_if.alloc_ready_out, 0);
        chk("full_count",       rob_if.count_out, 16);
        chk("full_no_commit",   rob_if.commit_valid_out, 0);
        tick();
        idle();
        #1;
        chk("c0_valid", rob_if.commit_valid_out, 1);
        chk("c0_id",    rob_if.commit_id_out, 0);
        chk("c0_rd",    rob_if.commit_rd_out, 1);
        chk("c0_value", rob_if.commit_value_out, 32'hA0);
        chk("c0_count", rob_if.count_out, 16);
        tick();
        chk("post_c0_count", rob_if.count_out, 15);
        chk("post_c0_ready", rob_if.alloc_ready_out, 1);
        chk("post_c0_tail",  rob_if.alloc_id_out, 0);
        alloc(KIND_ALU, 5'd9, 32'h0, 1'b0);
        tick();
        idle();
        #1;
        chk("refill_count", rob_if.count_out, 16);
        chk("refill_tail",  rob_if.alloc_id_out, 1);

        // ---- mispredicted branch at id 3
        do_reset();
        alloc(KIND_ALU, 5'd1, 32'h0, 1'b0); tick();
        alloc(KIND_ALU, 5'd2, 32'h0, 1'b0); tick();
        alloc(KIND_ALU, 5'd3, 32'h0, 1'b0); tick();
        alloc(KIND_BRANCH, 5'd5, 32'h0, 1'b0); tick();
        idle();
        cdb(0, 4'd0, 32'h10, 1'b0, 32'h0);
        cdb(1, 4'd1, 32'h11, 1'b0, 32'h0);
        tick();
        idle();
        cdb(0, 4'd2, 32'h12, 1'b0, 32'h0);
        cdb(1, 4'd3, 32'h0, 1'b1, 32'h1040);
        #1;
        chk("br_c0_id",    rob_if.commit_id_out, 0);
        chk("br_c0_value", rob_if.commit_value_out, 32'h10);
        chk("br_c0_flush", rob_if.flush_out, 0);
        tick();
        idle();
        tick();
        tick();
        alloc(KIND_ALU, 5'd6, 32'h0, 1'b0);      // discarded by the flush
        #1;
        chk("br_commit_vld", rob_if.commit_valid_out, 1);
        chk("br_commit_id",  rob_if.commit_id_out, 3);
        chk("br_flush",      rob_if.flush_out, 1);
        chk("br_redirect",   rob_if.redirect_pc_out, 32'h1040);
        chk("br_rd_forced",  rob_if.commit_rd_out, 0);
        chk("br_alloc_rdy",  rob_if.alloc_ready_out, 0);
        tick();
        idle();
        #1;
        chk("br_post_count", rob_if.count_out, 0);
        chk("br_post_flush", rob_if.flush_out, 0);
        chk("br_post_tail",  rob_if.alloc_id_out, 0);

        // ---- store handshake
        do_reset();
        alloc(KIND_STORE, 5'd4, 32'h0, 1'b0);
        tick();
        idle();
        #1;
        chk("st_wait_vld", rob_if.store_commit_valid_out, 0);
        cdb(0, 4'd0, 32'h55, 1'b0, 32'h0);
        tick();
        idle();
        rob_if.query_id_in = {4'd1, 4'd0};
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("st_hold_vld",    rob_if.store_commit_valid_out, 1);
            chk("st_hold_commit", rob_if.commit_valid_out, 0);
            tick();
        end
        chk("st_query_rdy", rob_if.query_ready_out, 2'b01);
        rob_if.store_commit_ack_in = 1'b1;
        #1;
        chk("st_ack_commit", rob_if.commit_valid_out, 0);
        tick();
        idle();
        #1;
        chk("st_commit_vld",   rob_if.commit_valid_out, 1);
        chk("st_commit_rd",    rob_if.commit_rd_out, 0);
        chk("st_commit_value", rob_if.commit_value_out, 32'h55);
        chk("st_sready_gone",  rob_if.store_commit_valid_out, 0);
        tick();
        chk("st_post_count", rob_if.count_out, 0);

        // ---- dual CDB completion and queries
        do_reset();
        for (int i = 0; i < 6; i++) begin
            alloc(KIND_ALU, 5'(i + 1), 32'h0, 1'b0);
            tick();
        end
        idle();
        cdb(0, 4'd2, 32'h222, 1'b0, 32'h0);
        cdb(1, 4'd5, 32'h555, 1'b0, 32'h0);
        rob_if.query_id_in = {4'd5, 4'd2};
`ifdef ROB_BYPASS_EN
        exp_rdy = 2'b11; exp_v0 = 32'h222; exp_v1 = 32'h555;
`else
        exp_rdy = 2'b00; exp_v0 = 32'h0;   exp_v1 = 32'h0;
`endif
        #1;
        chk("q_same_rdy", rob_if.query_ready_out, exp_rdy);
        chk("q_same_v0",  rob_if.query_value_out[XLEN-1:0], exp_v0);
        chk("q_same_v1",  rob_if.query_value_out[2*XLEN-1:XLEN], exp_v1);
        tick();
        idle();
        #1;
        chk("q_next_rdy", rob_if.query_ready_out, 2'b11);
        chk("q_next_v0",  rob_if.query_value_out[XLEN-1:0], 32'h222);
        chk("q_next_v1",  rob_if.query_value_out[2*XLEN-1:XLEN], 32'h555);
        chk("q_no_commit", rob_if.commit_valid_out, 0);
        rob_if.query_id_in = {4'd3, 4'd7};
        #1;
        chk("q_empty_wait_rdy", rob_if.query_ready_out, 2'b00);
        rob_if.query_id_in = '0;

        // ---- pre-completed LUI
        do_reset();
        alloc(KIND_DONE, 5'd7, 32'h12345000, 1'b0);
        tick();
        idle();
        #1;
        chk("lui_valid", rob_if.commit_valid_out, 1);
        chk("lui_rd",    rob_if.commit_rd_out, 7);
        chk("lui_value", rob_if.commit_value_out, 32'h12345000);
        tick();
        chk("lui_count", rob_if.count_out, 0);

        // ---- rdy_in freeze, then asynchronous reset mid-run
        do_reset();
        for (int i = 0; i < 9; i++) begin
            alloc(KIND_ALU, 5'(i + 1), 32'h0, 1'b0);
            tick();
        end
        idle();
        cdb(0, 4'd0, 32'h99, 1'b0, 32'h0);
        #1;
        chk("run_count9", rob_if.count_out, 9);
        tick();
        idle();
        rdy_in = 1'b0;
        alloc(KIND_ALU, 5'd20, 32'h0, 1'b0);
        #1;
        chk("frz_commit", rob_if.commit_valid_out, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_count",  rob_if.count_out, 9);
            chk("frz_commit", rob_if.commit_valid_out, 0);
        end
        idle();
        rdy_in = 1'b1;
        #1;
        chk("thaw_commit", rob_if.commit_valid_out, 1);
        chk("thaw_value",  rob_if.commit_value_out, 32'h99);
        chk("thaw_tail",   rob_if.alloc_id_out, 9);
        rst_n_in = 1'b0;
        #1;
        chk("arst_count",  rob_if.count_out, 0);
        chk("arst_commit", rob_if.commit_valid_out, 0);
        chk("arst_value",  rob_if.commit_value_out, 0);
        chk("arst_tail",   rob_if.alloc_id_out, 0);
        chk("arst_full",   rob_if.full_out, 0);
        rst_n_in = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reorder_buffer_v2.md
Name: reorder_buffer_v2

Overview:
Parametrised in-order-commit reorder buffer for the out-of-order core. It allocates entries from decode and collects results from NUM_CDB result buses. It serves two operand lookups, commits one entry per cycle to the register file, and gates store retirement through an LSB handshake. It also detects branch/JALR redirects at commit and flushes the whole pipeline.

Parameters:
DEPTH, 16, entries; power of 2, at least 4; ID_W = $clog2(DEPTH)
XLEN, 32, data/address width
NUM_CDB, 2, result-bus channels
RF_AW, 5, register index width

Ports:
clk_in  in  1  clock
rst_n_in  in  1  asynchronous active-low reset
rdy_in  in  1  global enable; low freezes all state, outputs hold
alloc_valid_in  in  1  decode offers an entry
alloc_ready_out  out  1  = !full_out && !flush_out
alloc_id_out  out  ID_W  tail index; the id the offered entry receives
alloc_kind_in  in  3  ALU, LOAD, STORE, BRANCH, JALR, DONE (LUI/AUIPC/JAL, pre-completed)
alloc_rd_in  in  RF_AW  destination register; 0 means no writeback
alloc_value_in  in  XLEN  result for DONE kinds
alloc_pred_taken_in  in  1  predictor decision (BRANCH only)
cdb_valid_in  in  NUM_CDB  per-channel valid
cdb_id_in  in  NUM_CDB*ID_W  entry id per channel
cdb_value_in  in  NUM_CDB*XLEN  result (JALR: link value)
cdb_taken_in  in  NUM_CDB  actual branch outcome
cdb_npc_in  in  NUM_CDB*XLEN  correct next PC (BRANCH/JALR)
query_id_in  in  2*ID_W  operand lookup ids
query_ready_out  out  2  entry result available
query_value_out  out  2*XLEN  entry result
commit_valid_out  out  1  head retires this cycle
commit_id_out  out  ID_W  head id
commit_rd_out  out  RF_AW  head destination register
commit_value_out  out  XLEN  head result
store_commit_valid_out  out  1  head is a STORE awaiting memory
store_commit_ack_in  in  1  LSB has performed the store
flush_out  out  1  mispredict/JALR redirect at commit
redirect_pc_out  out  XLEN  new fetch PC when flush_out is high
full_out  out  1  count == DEPTH
count_out  out  ID_W+1  occupancy

Behaviour:
- Reset (asynchronous, rst_n_in low): head=tail=0, count=0, all entry states cleared to EMPTY.
  - All *_out low/zero, except alloc_ready_out=1 once out of reset.
- Per-entry state: EMPTY -> WAIT -> DONE; a STORE goes WAIT -> SREADY -> DONE.
  - Allocation of a DONE kind enters DONE directly.
- Allocate on alloc_valid_in && alloc_ready_out: write entry[tail]; tail = tail+1 mod DEPTH; count+1.
- CDB write on cdb_valid_in[k] when entry[id] is WAIT: store value, npc and taken; go DONE.
  - STORE entries go SREADY instead of DONE (the address/data are held in the LSB).
  - A write to an EMPTY or DONE entry is ignored.
  - Two channels with the same id in one cycle: the higher k wins; this is a protocol error and is flagged only in simulation.
- Commit is combinational from the head entry. commit_valid_out = head DONE && !empty && rdy_in.
  - commit_rd_out is forced to 0 for STORE and BRANCH.
  - At the edge: entry becomes EMPTY, head+1, count-1.
- Store handshake: store_commit_valid_out = head SREADY.
  - store_commit_ack_in high moves head to DONE; it commits next cycle at the earliest.
  - An ack without valid is ignored.
- Flush: flush_out = commit_valid_out && (JALR || (BRANCH && taken != pred)); redirect_pc_out = entry npc.
  - At that edge all entries go EMPTY, head=tail=0, count=0.
  - Allocation and CDB writes in the same cycle are discarded.
- Simultaneous allocate and commit: count unchanged.
  - Allocate while full is blocked by alloc_ready_out.
  - Allocating into the head slot is only legal when count==0.
- Query: query_ready_out[i] = entry DONE or SREADY-with-value; the output is combinational.
  - Querying an EMPTY id returns ready=0.
- Wrap-around: head and tail roll from DEPTH-1 to 0. Full is distinguished from empty by count.

Optional Feature:
ROB_BYPASS_EN
- Defined: query_ready/query_value also forward any same-cycle cdb_valid_in hit on query_id (higher k wins).
- Undefined: a result becomes visible the cycle after its CDB write.

Decomposition:
- Package rob_pkg: the kind enum (3b), the entry-state enum (2b) and the opcode-to-kind constants.
- One sub-module, rob_query_port: the per-port lookup mux plus the optional CDB bypass, instantiated twice.

Test Plan:
- Allocate 16 ALU entries, DEPTH=16 -> full_out=1, alloc_ready_out=0, count_out=16; CDB completes id 0 -> commit of id 0 next cycle and alloc accepted again at tail 0.
- Branch at id 3 pred=0, CDB taken=1, npc=0x1040 -> on its commit flush_out=1, redirect_pc_out=0x1040, count_out=0 the next cycle.
- STORE at head, CDB write -> store_commit_valid_out=1; hold ack low 5 cycles -> no commit; ack -> commit the following cycle with commit_rd_out=0.
- Both CDB channels complete ids 2 and 5 in one cycle -> both DONE; queries on 2 and 5 return the values (same cycle with ROB_BYPASS_EN).
- DONE-kind alloc (LUI, rd=7, 0x12345000) at empty ROB -> commit next cycle, commit_value_out=0x12345000.
- Assert rst_n_in mid-run with 9 entries -> all outputs zero immediately, count_out=0; rdy_in low for 3 cycles -> state frozen, no commit.
